// File: rtl/exe_md_unit_pkg.sv
// Shared op codes, FSM states and helpers for the EXE multiply/divide unit.
package exe_md_unit_pkg;

    localparam int MD_OP_WD = 3;

    typedef enum logic [MD_OP_WD-1:0] {
        MD_OP_MULT  = 3'd0,
        MD_OP_MULTU = 3'd1,
        MD_OP_DIV   = 3'd2,
        MD_OP_DIVU  = 3'd3,
        MD_OP_MTHI  = 3'd4,
        MD_OP_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV
    } md_state_e;

    function automatic logic op_is_signed(input logic [MD_OP_WD-1:0] op);
        return (op == MD_OP_MULT) || (op == MD_OP_DIV);
    endfunction

endpackage

// File: rtl/exe_md_unit_if.sv
// Request handshake between EXE decode and the multiply/divide unit.
interface exe_md_unit_if
    import exe_md_unit_pkg::*;
#(
    parameter int XLEN = 32
);
    logic                req_valid;
    logic                req_ready;
    logic [MD_OP_WD-1:0] req_op;
    logic [XLEN-1:0]     req_src1;
    logic [XLEN-1:0]     req_src2;

    modport master (
        output req_valid, req_op, req_src1, req_src2,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_op, req_src1, req_src2,
        output req_ready
    );
endinterface

// File: rtl/exe_md_unit_div.sv
// Iterative radix-2 restoring divider: magnitudes at start, one quotient bit
// per cycle, sign fix applied on the result outputs.
module md_div_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            start_i,
    input  logic            kill_i,
    input  logic            signed_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] quotient_o,
    output logic [XLEN-1:0] remainder_o
);
    localparam int CW = $clog2(XLEN + 1);

    logic            busy_q;
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] dvd_q;
    logic [XLEN-1:0] dvs_q;
    logic [XLEN-1:0] rem_q;
    logic            qneg_q;
    logic            rneg_q;

    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   diff;
    logic            qbit;
    logic [XLEN-1:0] rem_nx;

    assign a_neg = signed_i & dividend_i[XLEN-1];
    assign b_neg = signed_i & divisor_i[XLEN-1];
    assign a_mag = a_neg ? -dividend_i : dividend_i;
    assign b_mag = b_neg ? -divisor_i : divisor_i;

    // Quotient bits shift into the dividend register as its bits are consumed.
    assign rem_sh = {rem_q, dvd_q[XLEN-1]};
    assign diff   = rem_sh - {1'b0, dvs_q};
    assign qbit   = ~diff[XLEN];
    assign rem_nx = qbit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];

    assign busy_o      = busy_q;
    assign done_o      = busy_q && (cnt_q == '0) && !kill_i;
    assign quotient_o  = qneg_q ? -dvd_q : dvd_q;
    assign remainder_o = rneg_q ? -rem_q : rem_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else if (kill_i) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else if (start_i) begin
            busy_q <= 1'b1;
            cnt_q  <= CW'(XLEN);
        end else if (busy_q) begin
            if (cnt_q == '0) begin
                busy_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (start_i) begin
            dvd_q  <= a_mag;
            dvs_q  <= b_mag;
            rem_q  <= '0;
            qneg_q <= a_neg ^ b_neg;
            rneg_q <= a_neg;
        end else if (busy_q && cnt_q != '0) begin
            dvd_q <= {dvd_q[XLEN-2:0], qbit};
            rem_q <= rem_nx;
        end
    end

endmodule

// File: rtl/exe_md_unit.sv
// EXE-stage multiply/divide unit with private HI/LO registers, pipelined
// multiplier and iterative divider.
module exe_md_unit
    import exe_md_unit_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int MUL_LAT = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    exe_md_unit_if.slave     req,
    output logic             busy_o,
    output logic             done_o,
    output logic [XLEN-1:0]  hi_o,
    output logic [XLEN-1:0]  lo_o
);
    md_state_e         state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic              done_q, done_d;
    logic              accept;
    logic              div_start;
    logic              div_busy;
    logic              div_done;
    logic [XLEN-1:0]   div_quot;
    logic [XLEN-1:0]   div_rem;
    logic              op_sgn;
    logic [2*XLEN-1:0] m1;
    logic [2*XLEN-1:0] m2;
    logic [2*XLEN-1:0] prod_q [MUL_LAT];

    assign req.req_ready = (state_q == ST_IDLE);
    assign busy_o        = (state_q != ST_IDLE);
    assign done_o        = done_q;
    assign hi_o          = hi_q;
    assign lo_o          = lo_q;
    assign accept        = req.req_valid && req.req_ready && !flush;
    assign op_sgn        = op_is_signed(req.req_op);

    // Low 2*XLEN product bits only depend on the low 2*XLEN operand bits.
    assign m1 = {{XLEN{op_sgn & req.req_src1[XLEN-1]}}, req.req_src1};
    assign m2 = {{XLEN{op_sgn & req.req_src2[XLEN-1]}}, req.req_src2};

    always_ff @(posedge clk) begin
        prod_q[0] <= m1 * m2;
        for (int i = 1; i < MUL_LAT; i++) begin
            prod_q[i] <= prod_q[i-1];
        end
    end

    md_div_iter #(
        .XLEN (XLEN)
    ) u_div (
        .clk         (clk),
        .resetn      (resetn),
        .start_i     (div_start),
        .kill_i      (flush),
        .signed_i    (op_sgn),
        .dividend_i  (req.req_src1),
        .divisor_i   (req.req_src2),
        .busy_o      (div_busy),
        .done_o      (div_done),
        .quotient_o  (div_quot),
        .remainder_o (div_rem)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        div_start = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    unique case (req.req_op)
                        MD_OP_MULT, MD_OP_MULTU: begin
                            state_d = ST_MUL;
                            cnt_d   = 3'(MUL_LAT - 1);
                        end
                        MD_OP_DIV, MD_OP_DIVU: begin
                            state_d   = ST_DIV;
                            div_start = 1'b1;
                        end
                        MD_OP_MTHI: begin
                            hi_d   = req.req_src1;
                            done_d = 1'b1;
                        end
                        MD_OP_MTLO: begin
                            lo_d   = req.req_src1;
                            done_d = 1'b1;
                        end
                        default: done_d = 1'b1;
                    endcase
                end
            end
            ST_MUL: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    {hi_d, lo_d} = prod_q[MUL_LAT-1];
                    state_d      = ST_IDLE;
                    done_d       = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DIV: begin
                if (flush || !div_busy) begin
                    state_d = ST_IDLE;
                end else if (div_done) begin
                    hi_d    = div_rem;
                    lo_d    = div_quot;
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

endmodule
